// File: rtl/downstream_mem_arbiter_if.sv
// downstream_mem_arbiter_if: requester and memory write-port signals shared by the arbiter and its environment
interface downstream_mem_arbiter_if #(
    parameter int N_REQ  = 4,
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    logic [N_REQ-1:0]        req;
    logic [N_REQ*ADDR_W-1:0] req_addr;
    logic [N_REQ*DATA_W-1:0] req_data;
    logic                    mem_ready;
    logic [N_REQ-1:0]        grant;
    logic [N_REQ-1:0]        done;
    logic [N_REQ-1:0]        err;
    logic                    mem_we;
    logic [ADDR_W-1:0]       mem_addr;
    logic [DATA_W-1:0]       mem_wdata;
    logic                    busy;

    modport master (
        input  req, req_addr, req_data, mem_ready,
        output grant, done, err, mem_we, mem_addr, mem_wdata, busy
    );

    modport slave (
        output req, req_addr, req_data, mem_ready,
        input  grant, done, err, mem_we, mem_addr, mem_wdata, busy
    );
endinterface

// File: rtl/downstream_mem_arbiter.sv
// downstream_mem_arbiter: round-robin owner of a shared memory write port with
// latched address/data, one-cycle grant setup, timeout abort and release cycle.
module downstream_mem_arbiter #(
    parameter int N_REQ   = 4,
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input logic clk,
    input logic rst,
    downstream_mem_arbiter_if.master bus
);
    localparam int IW = N_REQ > 1 ? $clog2(N_REQ) : 1;
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, GRANT, WRITE, RELEASE} state_t;

    state_t            state_q;
    logic [IW-1:0]     last_q, win_q, win_d;
    logic [CW-1:0]     cnt_q;
    logic [ADDR_W-1:0] addr_q, mem_addr_q;
    logic [DATA_W-1:0] data_q, mem_wdata_q;
    logic [N_REQ-1:0]  grant_q, done_q, err_q;
    logic              mem_we_q;
    int                idx;

    // Scan from farthest to nearest so the requester closest after last_q wins.
    always_comb begin
        win_d = '0;
        idx = 0;
        for (int k = N_REQ; k >= 1; k--) begin
            idx = (int'(last_q) + k) % N_REQ;
            if (bus.req[idx]) win_d = IW'(idx);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            last_q      <= IW'(N_REQ - 1);
            win_q       <= '0;
            cnt_q       <= '0;
            addr_q      <= '0;
            data_q      <= '0;
            grant_q     <= '0;
            done_q      <= '0;
            err_q       <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            done_q <= '0;
            err_q  <= '0;
            case (state_q)
                IDLE: if (|bus.req) begin
                    state_q <= GRANT;
                    win_q   <= win_d;
                    addr_q  <= bus.req_addr[win_d*ADDR_W +: ADDR_W];
                    data_q  <= bus.req_data[win_d*DATA_W +: DATA_W];
                    grant_q <= N_REQ'(1) << win_d;
                end
                GRANT: begin
                    state_q     <= WRITE;
                    cnt_q       <= CW'(1);
                    mem_we_q    <= 1'b1;
                    mem_addr_q  <= addr_q;
                    mem_wdata_q <= data_q;
                end
                WRITE: if (bus.mem_ready || cnt_q == CW'(TIMEOUT)) begin
                    // A ready on the final counted cycle still completes normally.
                    state_q       <= RELEASE;
                    grant_q       <= '0;
                    mem_we_q      <= 1'b0;
                    mem_addr_q    <= '0;
                    mem_wdata_q   <= '0;
                    done_q[win_q] <= bus.mem_ready;
                    err_q[win_q]  <= !bus.mem_ready;
                end else begin
                    cnt_q <= cnt_q + CW'(1);
                end
                RELEASE: begin
                    state_q <= IDLE;
                    last_q  <= win_q;
                    cnt_q   <= '0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.grant     = grant_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.busy      = state_q != IDLE;
endmodule

// File: tb/tb_downstream_mem_arbiter.sv
// tb_downstream_mem_arbiter: scoreboard bench; each stimulus pushes the expected
// completion, and the monitor pops and compares on every done/err pulse.
module tb_downstream_mem_arbiter;
    localparam int N = 4, AW = 8, DW = 32, TO = 16;

    typedef struct {
        int          idx;
        logic [7:0]  addr;
        logic [31:0] data;
        bit          is_err;
        int          we;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    exp_t sb[$];
    int   n_checks = 0, n_errors = 0, n_done = 0, we_cnt = 0, g_cnt = 0;
    logic [7:0]  last_addr;
    logic [31:0] last_data;

    downstream_mem_arbiter_if #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

    downstream_mem_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] addr_of(input int i);
        return 8'h10 + 8'(i);
    endfunction

    function automatic logic [31:0] data_of(input int i);
        return 32'hA5A5_0000 + 32'(i);
    endfunction

    task automatic push(input int i, input logic [7:0] a, input logic [31:0] d, input bit e, input int we);
        exp_t x;
        x.idx = i; x.addr = a; x.data = d; x.is_err = e; x.we = we;
        sb.push_back(x);
    endtask

    task automatic mon();
        exp_t e;
        logic [N-1:0] v;
        if (rst) begin
            we_cnt = 0;
            g_cnt = 0;
            return;
        end
        if (bus.mem_we) begin
            we_cnt++;
            last_addr = bus.mem_addr;
            last_data = bus.mem_wdata;
        end else if (bus.busy) chk("bus_zero_outside_write", {bus.mem_addr, bus.mem_wdata}, 0);
        if (|bus.grant) begin
            g_cnt++;
            chk("grant_onehot", 64'($onehot(bus.grant)), 1);
        end
        if (|bus.done || |bus.err) begin
            chk("pulse_exclusive", {$onehot0(bus.done), $onehot0(bus.err), |bus.done && |bus.err}, 3'b110);
            chk("grant_in_release", bus.grant, 0);
            if (sb.size() == 0) chk("unexpected_pulse", {bus.done, bus.err}, 0);
            else begin
                e = sb.pop_front();
                v = N'(1) << e.idx;
                chk("done", bus.done, e.is_err ? '0 : v);
                chk("err", bus.err, e.is_err ? v : '0);
                chk("addr", last_addr, e.addr);
                chk("wdata", last_data, e.data);
                chk("we_cycles", we_cnt, e.we);
                chk("grant_cycles", g_cnt, e.we + 1);
            end
            we_cnt = 0;
            g_cnt = 0;
            n_done++;
        end
    endtask

    task automatic wait_done(input string tag, output int cyc);
        int start = n_done;
        cyc = 0;
        while (n_done == start && cyc < 200) begin
            @(negedge clk); #1;
            cyc++;
        end
        if (n_done == start) chk(tag, 0, 1);
    endtask

    task automatic wait_we(input int n);
        int k = 0, cyc = 0;
        while (k < n && cyc < 200) begin
            @(negedge clk); #1;
            cyc++;
            if (bus.mem_we) k++;
        end
        if (k < n) chk("we_wait_expired", k, n);
    endtask

    initial begin
        int cyc;
        rst = 1'b1;
        bus.req = '1;
        bus.mem_ready = 1'b1;
        for (int i = 0; i < N; i++) begin
            bus.req_addr[i*AW +: AW] = addr_of(i);
            bus.req_data[i*DW +: DW] = data_of(i);
        end
        fork
            forever begin
                @(negedge clk);
                mon();
            end
        join_none
        repeat (2) begin @(negedge clk); #1; end
        chk("rst_outputs", {bus.grant, bus.done, bus.err, bus.mem_we, bus.busy}, 0);
        chk("rst_bus", {bus.mem_addr, bus.mem_wdata}, 0);
        bus.req = '0;
        rst = 1'b0;
        @(negedge clk); #1;

        // Fairness: all requesting, order 0,1,2,3,0
        push(0, addr_of(0), data_of(0), 0, 1);
        push(1, addr_of(1), data_of(1), 0, 1);
        push(2, addr_of(2), data_of(2), 0, 1);
        push(3, addr_of(3), data_of(3), 0, 1);
        push(0, addr_of(0), data_of(0), 0, 1);
        bus.req = 4'b1111;
        for (int i = 0; i < 5; i++) wait_done("fair_done_expired", cyc);
        bus.req = '0;
        @(negedge clk); #1;

        // Single requester with minimum latency
        bus.req_addr[1*AW +: AW] = 8'h3C;
        bus.req_data[1*DW +: DW] = 32'hDEAD_BEEF;
        push(1, 8'h3C, 32'hDEAD_BEEF, 0, 1);
        bus.req = 4'b0010;
        wait_done("single_done_expired", cyc);
        chk("single_latency", cyc, 3);
        bus.req = '0;
        @(negedge clk); #1;
        chk("single_idle", bus.busy, 0);

        // Timeout
        bus.mem_ready = 1'b0;
        push(2, addr_of(2), data_of(2), 1, TO);
        bus.req = 4'b0100;
        wait_done("timeout_err_expired", cyc);
        bus.req = '0;
        chk("busy_at_err", bus.busy, 1);
        @(negedge clk); #1;
        chk("busy_fall", bus.busy, 0);

        // Ready on the last counted cycle
        push(0, addr_of(0), data_of(0), 0, TO);
        bus.req = 4'b0001;
        wait_we(TO);
        bus.mem_ready = 1'b1;
        wait_done("last_ready_expired", cyc);
        bus.req = '0;
        bus.mem_ready = 1'b0;
        @(negedge clk); #1;

        // Input change after latching
        push(3, addr_of(3), data_of(3), 0, 3);
        bus.req = 4'b1000;
        wait_we(2);
        bus.req = '0;
        bus.req_data[3*DW +: DW] = 32'h0BAD_F00D;
        bus.req_addr[3*AW +: AW] = 8'hEE;
        wait_we(1);
        bus.mem_ready = 1'b1;
        wait_done("change_done_expired", cyc);
        bus.req_addr[3*AW +: AW] = addr_of(3);
        bus.req_data[3*DW +: DW] = data_of(3);
        bus.mem_ready = 1'b0;
        @(negedge clk); #1;

        // Reset during WRITE cycle 3, then req[3] alone
        bus.req = 4'b0010;
        wait_we(3);
        rst = 1'b1;
        bus.req = '0;
        @(negedge clk); #1;
        chk("rst_mid_outputs", {bus.grant, bus.done, bus.err, bus.mem_we, bus.busy}, 0);
        chk("rst_mid_bus", {bus.mem_addr, bus.mem_wdata}, 0);
        rst = 1'b0;
        bus.mem_ready = 1'b1;
        push(3, addr_of(3), data_of(3), 0, 1);
        bus.req = 4'b1000;
        wait_done("post_rst_done_expired", cyc);
        chk("post_rst_latency", cyc, 3);
        bus.req = '0;

        // Priority returns to req[0] after reset
        rst = 1'b1;
        @(negedge clk); #1;
        rst = 1'b0;
        push(0, addr_of(0), data_of(0), 0, 1);
        push(2, addr_of(2), data_of(2), 0, 1);
        bus.req = 4'b0101;
        wait_done("prio_a_expired", cyc);
        bus.req = 4'b0100;
        wait_done("prio_b_expired", cyc);
        bus.req = '0;
        repeat (4) begin @(negedge clk); #1; end
        chk("sb_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/downstream_mem_arbiter.md
DOWNSTREAM_MEM_ARBITER -- requirements
Module: downstream_mem_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, number of downstream processors sharing the memory write port.
REQ-002 Parameter ADDR_W, default 8, memory address width.
REQ-003 Parameter DATA_W, default 32, memory write data width.
REQ-004 Parameter TIMEOUT, default 16, maximum WRITE-state cycles without mem_ready before abort.
REQ-005 The block SHALL use one clock; reset is synchronous and active-high.
REQ-006 clk  input  1  rising-edge clock.
REQ-007 rst  input  1  synchronous active-high reset.
REQ-008 req  input  N_REQ  bit i high: requester i has a pending memory update; held until done[i] or err[i].
REQ-009 req_addr  input  N_REQ*ADDR_W  slice i: address from requester i.
REQ-010 req_data  input  N_REQ*DATA_W  slice i: write data from requester i.
REQ-011 mem_ready  input  1  memory accepted the write this cycle.
REQ-012 grant  output  N_REQ  one-hot: current owner of the write port.
REQ-013 done  output  N_REQ  one-cycle pulse: requester i's write completed.
REQ-014 err  output  N_REQ  one-cycle pulse: requester i's write aborted by timeout.
REQ-015 mem_we  output  1  memory write enable.
REQ-016 mem_addr  output  ADDR_W  write address.
REQ-017 mem_wdata  output  DATA_W  write data.
REQ-018 busy  output  1  high whenever state is not IDLE.

Function
REQ-019 The block SHALL implement a registered FSM with states IDLE, GRANT, WRITE, RELEASE; all outputs registered or decoded from registers only.
REQ-020 IDLE: if any req bit is high at the clock edge, the block SHALL select the winner, latch its addr/data, set grant[winner], and go to GRANT; otherwise stay in IDLE.
REQ-021 Arbitration SHALL be round-robin: priority starts at (last_winner+1) mod N_REQ; last_winner resets to N_REQ-1, so req[0] has top priority after reset.
REQ-022 GRANT SHALL last exactly one cycle, then go to WRITE.
REQ-023 WRITE: mem_we=1, mem_addr/mem_wdata = latched values; on an edge with mem_ready=1 go to RELEASE with done[winner]=1 for the RELEASE cycle.
REQ-024 A cycle counter SHALL count WRITE cycles from 1; if mem_ready is still low when the count reaches TIMEOUT, go to RELEASE with err[winner]=1 and no done.
REQ-025 If mem_ready and timeout coincide on the same edge, done SHALL win; err SHALL stay low.
REQ-026 grant[winner] SHALL be high in GRANT and WRITE, low in RELEASE and IDLE.
REQ-027 RELEASE SHALL last one cycle, update last_winner, clear the counter, and return to IDLE.
REQ-028 Outside WRITE, mem_we, mem_addr and mem_wdata SHALL be 0; mem_ready SHALL be ignored.
REQ-029 A requester dropping req after GRANT SHALL NOT abort the transaction; the latched write completes.
REQ-030 req_addr/req_data changes after latching SHALL NOT affect mem_addr/mem_wdata.
REQ-031 Minimum service time with mem_ready held high: req sampled at edge E0, grant from E0, mem_we from E1, done during E2-E3, IDLE again from E3.
REQ-032 At most one bit of grant, done, err SHALL ever be high; done and err SHALL never be high together.

Reset
REQ-033 On rst at a clock edge: state IDLE, grant/done/err/mem_we/busy = 0, mem_addr/mem_wdata = 0, counter 0, last_winner = N_REQ-1.
REQ-034 Reset mid-transaction SHALL abandon it with no done or err pulse; rst SHALL override all other inputs.

Verification
REQ-035 Single requester: req=4'b0010, addr 0x3C, data 0xDEADBEEF, mem_ready=1 -> grant=0010 for 2 cycles, one mem_we cycle with addr 0x3C/data 0xDEADBEEF, done=0010 once.
REQ-036 Fairness: req=4'b1111 held, re-raised after each done, mem_ready=1 -> grant order 0,1,2,3,0; no requester served twice in a row.
REQ-037 Timeout: req[2]=1, mem_ready=0 -> mem_we high exactly 16 cycles, then err=0100 one cycle, done stays 0, busy falls next cycle.
REQ-038 Ready on last cycle: mem_ready rises on WRITE cycle 16 -> done pulses, err stays 0.
REQ-039 Reset mid-write: rst high during WRITE cycle 3 -> all outputs 0 next cycle, no done/err; next req[3] alone is then served normally.
REQ-040 Input change: req_data altered and req dropped during WRITE -> mem_wdata keeps latched value and done still pulses.
